load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port. Accepts load/store requests from the pipeline over a valid/ready handshake.
- Drives the byte-addressed, big-endian data memory: data_address, writeData, memRead, memWrite, dataRead. The memory transfers 4 bytes per access, from addr to addr+3.
- Byte and half loads are extracted from the word read, then extended. Byte and half stores use read-modify-write.
- Returns the load data or an error on a valid/ready response channel.

Parameters:
- ADDR_W, 10, width of the byte address
- MEM_BYTES, 1024, data memory size in bytes; highest legal access address is MEM_BYTES-4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request; high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend a sub-word load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; the operand is in the low bits
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  request rejected; no memory access was made
- data_address  out  ADDR_W  memory address
- writeData  out  64  memory write data; [63:32] always 0
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- dataRead  in  64  memory read data; [31:0] valid at the posedge after a memRead cycle

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE. req_ready=1 (combinational from state). All other outputs 0.
- All memory-side outputs and all response outputs are registered.
- Handshake: a request is accepted on a posedge with req_valid&&req_ready. The request fields are latched at acceptance.
- Error check at acceptance: resp_err=1 if req_size==11 or req_addr>MEM_BYTES-4.
  - Error path: IDLE->RESP, no memRead/memWrite.
- States and transitions:
  - IDLE: on accept, go to RD (load or sub-word store), WR (word store) or RESP (error).
  - RD: memRead=1 and data_address=addr for exactly one cycle; next state WAIT.
  - WAIT: memRead=0; capture dataRead[31:0] into the word register. Load->RESP, store->WR.
  - WR: memWrite=1 for exactly one cycle, data_address=addr, writeData[31:0]=merged word; next RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE.
- Latency, accept edge to resp_valid: load 3 cycles; word store 2; sub-word store 4; error 1.
- Load extraction from word w:
  - byte = w[31:24]
  - half = w[31:16]
  - word = w
  - Sub-word results are sign-extended if req_signed, else zero-extended.
- Store merge:
  - byte: w[31:24] replaced by wdata[7:0]
  - half: w[31:16] replaced by wdata[15:0]
  - word: wdata used directly, no read
  - req_signed is ignored for stores.
- memRead and memWrite are never high in the same cycle. Between accesses, data_address holds its last value.
- rst mid-operation: return to IDLE immediately with all strobes 0 in that cycle. A pending read or write is abandoned; no partial memWrite is ever issued.
- resp_ready high with resp_valid low is ignored.
- req_valid while busy: not accepted, and the request fields are not sampled.

Optional Feature:
- LSU_ALIGN_CHECK_EN
- Defined: a half request at an odd address, or a word request with addr[1:0]!=0, is rejected with resp_err=1 through the error path.
- Undefined: any alignment is legal, subject only to the MEM_BYTES-4 bound.

Test Plan:
- Word store addr=0x010, wdata=0xDEADBEEF, then word load at 0x010 -> exactly one memWrite pulse with writeData=0x00000000DEADBEEF; load returns resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept.
- Memory holds 0x80112233 at 0x020. Byte load signed -> 0xFFFFFF80. Byte load unsigned -> 0x00000080. Half load signed -> 0xFFFF8011.
- Byte store wdata=0x55 at 0x020 over 0x80112233 -> one memRead, then one memWrite with writeData[31:0]=0x55112233; word load then returns 0x55112233.
- Word load at addr=1021, and any request with req_size=11 -> resp_err=1, resp_rdata=0, memRead and memWrite never asserted, resp_valid 1 cycle after accept.
- resp_ready held low 5 cycles during RESP -> resp_valid and resp_rdata stable and req_ready=0 throughout. rst asserted during a store's WAIT state -> next cycle IDLE with no memWrite pulse.
- With LSU_ALIGN_CHECK_EN defined, half load at 0x021 -> resp_err=1. Without it -> normal data returned.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response channel between the pipeline and the load/store unit.
// The pipeline uses the master modport; the LSU uses the slave modport.
interface load_store_unit_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit driving a big-endian, word-wide data memory; sub-word stores use read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned half/word requests.
module load_store_unit #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  req_if,
  output logic [ADDR_W-1:0] data_address,
  output logic [63:0]       writeData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [63:0]       dataRead
);

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // Big-endian: the addressed byte/half sits in the top bits of the returned word.
  function automatic logic [31:0] extract_load(input logic [31:0] w,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: begin
        if (sgn) begin
          r = {{24{w[31]}}, w[31:24]};
        end else begin
          r = {24'h00_0000, w[31:24]};
        end
      end
      SIZE_HALF: begin
        if (sgn) begin
          r = {{16{w[31]}}, w[31:16]};
        end else begin
          r = {16'h0000, w[31:16]};
        end
      end
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {wdata[7:0], w[23:0]};
      SIZE_HALF: r = {wdata[15:0], w[15:0]};
      default:   r = wdata;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] data_address_q, data_address_d;
  logic [31:0]       write_data_q, write_data_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              misalign_s;
  logic              req_err_s;
  logic              unused_read_hi_s;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_s = ((req_if.req_size == SIZE_HALF) && req_if.req_addr[0]) ||
                      ((req_if.req_size == SIZE_WORD) && (req_if.req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign req_err_s = (req_if.req_size == SIZE_ILL) || (req_if.req_addr > MAX_ADDR) || misalign_s;

  // Only the low word of the memory bus carries data.
  assign unused_read_hi_s = ^dataRead[63:32];

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    size_d         = size_q;
    sgn_d          = sgn_q;
    wdata_d        = wdata_q;
    data_address_d = data_address_q;
    write_data_d   = write_data_q;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          we_d    = req_if.req_we;
          size_d  = req_if.req_size;
          sgn_d   = req_if.req_signed;
          wdata_d = req_if.req_wdata;
          if (req_err_s) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0000_0000;
          end else if (req_if.req_we && (req_if.req_size == SIZE_WORD)) begin
            state_d        = WR;
            mem_write_d    = 1'b1;
            data_address_d = req_if.req_addr;
            write_data_d   = req_if.req_wdata;
          end else begin
            state_d        = RD;
            mem_read_d     = 1'b1;
            data_address_d = req_if.req_addr;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (we_q) begin
          state_d      = WR;
          mem_write_d  = 1'b1;
          write_data_d = merge_store(dataRead[31:0], size_q, wdata_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = extract_load(dataRead[31:0], size_q, sgn_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
      end
      RESP: begin
        if (req_if.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0000_0000;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      size_q         <= 2'b00;
      sgn_q          <= 1'b0;
      wdata_q        <= 32'h0000_0000;
      data_address_q <= '0;
      write_data_q   <= 32'h0000_0000;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0000_0000;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      size_q         <= size_d;
      sgn_q          <= sgn_d;
      wdata_q        <= wdata_d;
      data_address_q <= data_address_d;
      write_data_q   <= write_data_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign req_if.req_ready  = (state_q == IDLE);
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_rdata = resp_rdata_q;
  assign req_if.resp_err   = resp_err_q;
  assign data_address      = data_address_q;
  assign writeData         = {32'h0000_0000, write_data_q};
  assign memRead           = mem_read_q;
  assign memWrite          = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: behavioural byte memory, hand-computed expected values.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  data_address;
  logic [63:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [63:0] data_read;

  load_store_unit_if #(.ADDR_W(10)) bus ();

  load_store_unit #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_if       (bus),
    .data_address (data_address),
    .writeData    (writeData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .dataRead     (data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [7:0]  mem [0:1023];
  int          rd_cnt;
  int          wr_cnt;
  int          both_cnt;
  int          hi_cnt;
  logic [63:0] last_wdata;
  logic [9:0]  last_waddr;

  // Synchronous memory: read data appears at the edge that samples memRead and holds.
  always @(posedge clk) begin
    if (memRead) begin
      data_read <= {32'h0000_0000, mem[data_address], mem[data_address + 10'd1],
                    mem[data_address + 10'd2], mem[data_address + 10'd3]};
      rd_cnt    <= rd_cnt + 1;
    end
    if (memWrite) begin
      mem[data_address]         <= writeData[31:24];
      mem[data_address + 10'd1] <= writeData[23:16];
      mem[data_address + 10'd2] <= writeData[15:8];
      mem[data_address + 10'd3] <= writeData[7:0];
      last_wdata <= writeData;
      last_waddr <= data_address;
      wr_cnt     <= wr_cnt + 1;
      if (writeData[63:32] != 32'h0000_0000) hi_cnt <= hi_cnt + 1;
    end
    if (memRead && memWrite) both_cnt <= both_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int  n;
    bit  seen;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check_val("accept_timeout", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = bus.resp_valid;
    end
    if (!seen) check_val("resp_timeout", 64'(bus.resp_valid), 64'd1);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [9:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_rd, input int exp_wr);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd0;
    int          wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_req(we, size, sgn, addr, wdata, rdata, err, lat);
    check_val({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
    check_val({tag, "_err"}, 64'(err), 64'(exp_err));
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(exp_rd));
    check_val({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    checks     = 0;
    failures   = 0;
    rd_cnt     = 0;
    wr_cnt     = 0;
    both_cnt   = 0;
    hi_cnt     = 0;
    last_wdata = 64'h0;
    last_waddr = 10'h0;
    data_read  = 64'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'h000;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_val("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check_val("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check_val("rst_mem_read", 64'(memRead), 64'd0);
    check_val("rst_mem_write", 64'(memWrite), 64'd0);
    check_val("rst_write_data", writeData, 64'd0);
    check_val("rst_data_address", 64'(data_address), 64'd0);
    rst = 1'b0;

    // Word store then word load.
    txn("st_w_010", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
    check_val("st_w_010_wdata", last_wdata, 64'h00000000_DEADBEEF);
    check_val("st_w_010_waddr", 64'(last_waddr), 64'h010);
    txn("ld_w_010", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);

    // Sub-word loads from 0x80112233.
    txn("st_w_020", 1'b1, 2'b10, 1'b0, 10'h020, 32'h80112233, 32'h0, 1'b0, 2, 0, 1);
    txn("ld_bs_020", 1'b0, 2'b00, 1'b1, 10'h020, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1, 0);
    txn("ld_bu_020", 1'b0, 2'b00, 1'b0, 10'h020, 32'h0, 32'h00000080, 1'b0, 3, 1, 0);
    txn("ld_hs_020", 1'b0, 2'b01, 1'b1, 10'h020, 32'h0, 32'hFFFF8011, 1'b0, 3, 1, 0);
    txn("ld_hu_020", 1'b0, 2'b01, 1'b0, 10'h020, 32'h0, 32'h00008011, 1'b0, 3, 1, 0);

    // Read-modify-write stores; only the low operand bits land in memory.
    txn("st_b_020", 1'b1, 2'b00, 1'b1, 10'h020, 32'hAAAAAA55, 32'h0, 1'b0, 4, 1, 1);
    check_val("st_b_020_wdata", last_wdata, 64'h00000000_55112233);
    txn("ld_w_020a", 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h55112233, 1'b0, 3, 1, 0);
    txn("st_h_020", 1'b1, 2'b01, 1'b0, 10'h020, 32'h9999ABCD, 32'h0, 1'b0, 4, 1, 1);
    check_val("st_h_020_wdata", last_wdata, 64'h00000000_ABCD2233);
    txn("ld_w_020b", 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'hABCD2233, 1'b0, 3, 1, 0);
    txn("ld_bs_020b", 1'b0, 2'b00, 1'b1, 10'h020, 32'h0, 32'hFFFFFFAB, 1'b0, 3, 1, 0);

    // Error path: out of range or illegal size.
    txn("err_ld_1021", 1'b0, 2'b10, 1'b0, 10'd1021, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_size11", 1'b0, 2'b11, 1'b0, 10'h000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    txn("err_st_1022", 1'b1, 2'b10, 1'b0, 10'd1022, 32'h12345678, 32'h0, 1'b1, 1, 0, 0);
    txn("err_ldb_1023", 1'b0, 2'b00, 1'b0, 10'd1023, 32'h0, 32'h0, 1'b1, 1, 0, 0);

    // Highest legal address.
    txn("st_w_1020", 1'b1, 2'b10, 1'b0, 10'd1020, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1);
    txn("ld_w_1020", 1'b0, 2'b10, 1'b0, 10'd1020, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0);

    // Misaligned half load at 0x021: bytes 0xCD,0x22.
`ifdef LSU_ALIGN_CHECK_EN
    txn("ld_hs_021", 1'b0, 2'b01, 1'b1, 10'h021, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
    txn("ld_hs_021", 1'b0, 2'b01, 1'b1, 10'h021, 32'h0, 32'hFFFFCD22, 1'b0, 3, 1, 0);
`endif

    // Response stall with a competing request presented while busy.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'h020;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("stall_resp_valid0", 64'(bus.resp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 10'h010;
      bus.req_size  = 2'b00;
      @(negedge clk);
      check_val("stall_resp_valid", 64'(bus.resp_valid), 64'd1);
      check_val("stall_resp_rdata", 64'(bus.resp_rdata), 64'hABCD2233);
      check_val("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check_val("stall_done_req_ready", 64'(bus.req_ready), 64'd1);
    check_val("stall_done_resp_valid", 64'(bus.resp_valid), 64'd0);

    // resp_ready while idle is ignored.
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_rr_resp_valid", 64'(bus.resp_valid), 64'd0);
    check_val("idle_rr_req_ready", 64'(bus.req_ready), 64'd1);
    bus.resp_ready = 1'b0;

    // Reset while a byte store sits in WAIT: no write may follow.
    wr0 = wr_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_addr   = 10'h010;
    bus.req_wdata  = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("rmw_rd_strobe", 64'(memRead), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    check_val("midrst_mem_write", 64'(memWrite), 64'd0);
    check_val("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midrst_writes", 64'(wr_cnt - wr0), 64'd0);
    txn("ld_w_010_post", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);

    check_val("strobe_overlap", 64'(both_cnt), 64'd0);
    check_val("write_hi_nonzero", 64'(hi_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
